// File: rtl/tx_pkg.sv
// Shared types and helpers for the TX lane unpacker: symbol/word widths,
// DataBusWidth encodings and the buffered word entry.
package tx_pkg;

   localparam int SYM_WIDTH = 8;
   localparam int MAC_WIDTH = 32;
   localparam int K_WIDTH   = MAC_WIDTH / SYM_WIDTH;

   localparam logic [5:0] W8  = 6'd8;
   localparam logic [5:0] W16 = 6'd16;
   localparam logic [5:0] W32 = 6'd32;

   localparam logic [SYM_WIDTH-1:0] IDLE_SYM = 8'h00;

   typedef struct packed {
      logic [MAC_WIDTH-1:0] data;
      logic [K_WIDTH-1:0]   k;
      logic [2:0]           lanes;
   } tx_entry_t;

   typedef struct packed {
      logic [2:0] lanes;
      logic       err;
   } lane_dec_t;

   // Unsupported widths still occupy one lane so the stream never stalls.
   function automatic lane_dec_t width_to_lanes(input logic [5:0] bus_width);
      lane_dec_t dec;
      case (bus_width)
         W32:     dec = '{lanes: 3'd4, err: 1'b0};
         W16:     dec = '{lanes: 3'd2, err: 1'b0};
         W8:      dec = '{lanes: 3'd1, err: 1'b0};
         default: dec = '{lanes: 3'd1, err: 1'b1};
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/tx_sym_fifo2.sv
// Two-entry word buffer between the MAC handshake and the byte serialiser.
// Head entry is presented combinationally; full/empty decode from state only.
//
//   state    | meaning
//   ---------+-----------------------------------------
//   ST_EMPTY | no word buffered
//   ST_ONE   | one word buffered (head valid)
//   ST_TWO   | both entries used; pushes are refused
module tx_sym_fifo2
   import tx_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  tx_entry_t wr_entry,
   output tx_entry_t rd_entry,
   output logic      full,
   output logic      empty
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_state_t;

   occ_state_t state;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       do_push;
   logic       do_pop;
   tx_entry_t  mem [DEPTH];

   // A push is refused in ST_TWO even if the head pops that cycle, so ready
   // never depends on the pop path.
   assign do_push  = push & (state != ST_TWO);
   assign do_pop   = pop & (state != ST_EMPTY);
   assign full     = (state == ST_TWO);
   assign empty    = (state == ST_EMPTY);
   assign rd_entry = mem[rd_ptr];

   // Occupancy FSM, pointers and storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_EMPTY;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   state <= (state == ST_EMPTY) ? ST_ONE : ST_TWO;
            2'b01:   state <= (state == ST_TWO) ? ST_ONE : ST_EMPTY;
            default: state <= state;
         endcase
      end
   end

endmodule

// File: rtl/tx_lane_unpacker.sv
// Byte serialiser feeding the 8b/10b encoder. Buffers up to two MAC words
// and emits one symbol per Bit_Rate_CLK_10 cycle with no bubble between words.
// Optional feature macro: TX_IDLE_FILL_EN -- when defined, empty cycles emit a
// valid logical idle (8'h00, K=0) instead of dropping Sym_Valid.
module tx_lane_unpacker
   import tx_pkg::tx_entry_t;
   import tx_pkg::lane_dec_t;
   import tx_pkg::width_to_lanes;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SYM_WIDTH  = 8,
   parameter int DEPTH      = 2
) (
   input  logic                    Bit_Rate_CLK_10,
   input  logic                    Reset_n,
   input  logic [DATA_WIDTH-1:0]   MAC_TX_Data,
   input  logic [DATA_WIDTH/8-1:0] MAC_TX_DataK,
   input  logic                    MAC_Data_En,
   input  logic [5:0]              DataBusWidth,
   output logic                    MAC_Ready,
   output logic [SYM_WIDTH-1:0]    Sym_Data,
   output logic                    Sym_K,
   output logic                    Sym_Valid,
   output logic                    Width_Err
);

   logic                 ready_en;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 lane_last;
   logic [1:0]           lane_idx;
   lane_dec_t            dec;
   tx_entry_t            wr_entry;
   tx_entry_t            head;
   logic [SYM_WIDTH-1:0] sym_data_q;
   logic                 sym_k_q;
   logic                 sym_valid_q;
   logic                 width_err_q;

   assign dec       = width_to_lanes(DataBusWidth);
   assign wr_entry  = '{data: MAC_TX_Data, k: MAC_TX_DataK, lanes: dec.lanes};
   assign MAC_Ready = ready_en & ~fifo_full;
   assign push      = MAC_Data_En & MAC_Ready;
   assign lane_last = ({1'b0, lane_idx} == (head.lanes - 3'd1));
   assign pop       = ~fifo_empty & lane_last;

   tx_sym_fifo2 #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (Bit_Rate_CLK_10),
      .rst_n    (Reset_n),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .rd_entry (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Hold off ready until the first edge after reset release.
   always_ff @(posedge Bit_Rate_CLK_10 or negedge Reset_n) begin
      if (!Reset_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Lane walk over the head word and registered symbol outputs.
   always_ff @(posedge Bit_Rate_CLK_10 or negedge Reset_n) begin
      if (!Reset_n) begin
         lane_idx    <= 2'd0;
         sym_data_q  <= '0;
         sym_k_q     <= 1'b0;
         sym_valid_q <= 1'b0;
         width_err_q <= 1'b0;
      end else begin
         width_err_q <= push & dec.err;
         if (!fifo_empty) begin
            sym_data_q  <= head.data[{lane_idx, 3'b000} +: SYM_WIDTH];
            sym_k_q     <= head.k[lane_idx];
            sym_valid_q <= 1'b1;
            lane_idx    <= lane_last ? 2'd0 : lane_idx + 2'd1;
         end else begin
`ifdef TX_IDLE_FILL_EN
            sym_data_q  <= tx_pkg::IDLE_SYM;
            sym_k_q     <= 1'b0;
            sym_valid_q <= 1'b1;
`else
            sym_valid_q <= 1'b0;
`endif
         end
      end
   end

   assign Sym_Data  = sym_data_q;
   assign Sym_K     = sym_k_q;
   assign Sym_Valid = sym_valid_q;
   assign Width_Err = width_err_q;

endmodule

// File: tb/tb_tx_lane_unpacker.sv
// Scoreboard bench for tx_lane_unpacker: accepted words are expanded into an
// expected symbol queue; a monitor compares every output cycle.
module tb_tx_lane_unpacker;

   logic        clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [31:0] MAC_TX_Data = '0;
   logic [3:0]  MAC_TX_DataK = '0;
   logic        MAC_Data_En = 1'b0;
   logic [5:0]  DataBusWidth = 6'd32;
   logic        MAC_Ready;
   logic [7:0]  Sym_Data;
   logic        Sym_K;
   logic        Sym_Valid;
   logic        Width_Err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      logic       k;
      bit         last;
   } sym_t;

   sym_t sym_q[$];
   int   words_acc  = 0;
   int   words_done = 0;
   bit   armed      = 0;
   bit   err_exp    = 0;
   bit   prev_ne    = 0;

   tx_lane_unpacker dut (
      .Bit_Rate_CLK_10 (clk),
      .Reset_n         (Reset_n),
      .MAC_TX_Data     (MAC_TX_Data),
      .MAC_TX_DataK    (MAC_TX_DataK),
      .MAC_Data_En     (MAC_Data_En),
      .DataBusWidth    (DataBusWidth),
      .MAC_Ready       (MAC_Ready),
      .Sym_Data        (Sym_Data),
      .Sym_K           (Sym_K),
      .Sym_Valid       (Sym_Valid),
      .Width_Err       (Width_Err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted word becomes its list of symbols, byte0 first.
   logic [31:0] wd;
   logic [3:0]  wk;
   logic [5:0]  ww;
   int          n_lanes;
   always @(posedge clk) begin
      if (!Reset_n) begin
         armed   = 0;
         err_exp = 0;
      end else begin
         err_exp = 0;
         if (MAC_Data_En && MAC_Ready) begin
            wd = MAC_TX_Data;
            wk = MAC_TX_DataK;
            ww = DataBusWidth;
            n_lanes = (ww == 6'd32) ? 4 : (ww == 6'd16) ? 2 : 1;
            err_exp = !(ww == 6'd8 || ww == 6'd16 || ww == 6'd32);
            for (int i = 0; i < n_lanes; i++) begin
               sym_q.push_back('{d: wd[8*i +: 8], k: wk[i], last: (i == n_lanes - 1)});
            end
            words_acc++;
         end
         armed = 1;
      end
   end

   // Monitor: a symbol is due whenever anything was queued before the last edge.
   sym_t e;
   always @(negedge clk) begin
      if (!Reset_n) begin
         chk("rst_ready", MAC_Ready, 0);
         chk("rst_valid", Sym_Valid, 0);
      end else begin
`ifdef TX_IDLE_FILL_EN
         chk("valid", Sym_Valid, armed);
`else
         chk("valid", Sym_Valid, prev_ne);
`endif
         if (prev_ne) begin
            e = sym_q.pop_front();
            chk("sym_data", Sym_Data, e.d);
            chk("sym_k", Sym_K, e.k);
            if (e.last) words_done++;
         end
`ifdef TX_IDLE_FILL_EN
         else if (armed) begin
            chk("idle_data", Sym_Data, 0);
            chk("idle_k", Sym_K, 0);
         end
`endif
         prev_ne = (sym_q.size() != 0);
         chk("mac_ready", MAC_Ready, armed && ((words_acc - words_done) < 2));
         chk("width_err", Width_Err, err_exp);
      end
   end

   task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic [5:0] w);
      bit done = 0;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk); #2;
         MAC_TX_Data  = d;
         MAC_TX_DataK = k;
         DataBusWidth = w;
         MAC_Data_En  = 1'b1;
         if (MAC_Ready) done = 1;
         @(posedge clk);
      end
      chk("ready_timeout", done, 1);
   endtask

   task automatic idle(input int n);
      @(negedge clk); #2;
      MAC_Data_En = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   logic [5:0] rw;
   int         sel;

   initial begin
      #1;
      chk("rst_sym_data", Sym_Data, 0);
      chk("rst_sym_k", Sym_K, 0);
      chk("rst_width_err", Width_Err, 0);
      repeat (3) @(negedge clk);
      #2 Reset_n = 1'b1;
      idle(4);

      // single 32-bit word with K on the last byte
      send_word(32'hBC4A_1C03, 4'b1000, 6'd32);
      idle(8);
      // back-to-back 32-bit words, enable held
      send_word(32'h8877_6655, 4'b0001, 6'd32);
      send_word(32'hF0E0_D0C0, 4'b0110, 6'd32);
      idle(12);
      // mixed widths
      send_word(32'h0000_BBAA, 4'b0000, 6'd16);
      send_word(32'h0000_00CC, 4'b0001, 6'd8);
      send_word(32'h4433_2211, 4'b0000, 6'd32);
      idle(12);
      // unsupported width
      send_word(32'h0000_00EE, 4'b0000, 6'd24);
      idle(6);

      // reset after the second byte of a 32-bit word
      send_word(32'hA1B2_C3D4, 4'b0101, 6'd32);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk); #2;
      Reset_n     = 1'b0;
      MAC_Data_En = 1'b0;
      sym_q.delete();
      words_acc  = 0;
      words_done = 0;
      prev_ne    = 0;
      #1;
      chk("midrst_valid", Sym_Valid, 0);
      chk("midrst_data", Sym_Data, 0);
      chk("midrst_k", Sym_K, 0);
      chk("midrst_ready", MAC_Ready, 0);
      repeat (3) @(negedge clk);
      #2 Reset_n = 1'b1;
      idle(8);

      // randomized traffic
      for (int w = 0; w < 150; w++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: rw = 6'd8;
            3, 4, 5: rw = 6'd16;
            6, 7, 8: rw = 6'd32;
            default: rw = 6'($urandom_range(0, 3) * 21);
         endcase
         send_word($urandom, 4'($urandom_range(0, 15)), rw);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
      end
      idle(12);
      chk("drain_empty", sym_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/tx_lane_unpacker.md
Name: tx_lane_unpacker

Overview:
- Byte-serialising stage directly upstream of the 8b/10b encoder in the PHY TX path.
- Accepts MAC words of 8/16/32 bits, selected per word by DataBusWidth, each carrying per-byte K flags.
- Emits exactly one byte-wide symbol plus its K flag per symbol clock to the encoder.
- A 2-word buffer keeps a continuous, bubble-free symbol stream while the MAC paces words with a ready handshake.

Parameters:
- DATA_WIDTH, 32, MAC word width in bits; fixed at 32, other values unsupported.
- SYM_WIDTH, 8, symbol width in bits.
- DEPTH, 2, word buffer entries; fixed at 2.

Ports:
- Bit_Rate_CLK_10  input  1  symbol-rate clock; all logic is on its rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- MAC_TX_Data  input  32  MAC data word; byte0 = bits[7:0], transmitted first.
- MAC_TX_DataK  input  4  per-byte K flag; bit i qualifies byte i.
- MAC_Data_En  input  1  word valid.
- DataBusWidth  input  6  active width in bits for the current word: 8, 16 or 32 (decimal).
- MAC_Ready  output  1  buffer can accept a word.
- Sym_Data  output  8  symbol to the encoder.
- Sym_K  output  1  K flag for Sym_Data.
- Sym_Valid  output  1  Sym_Data/Sym_K are meaningful this cycle.
- Width_Err  output  1  one-cycle pulse: an accepted word had an unsupported DataBusWidth.

Behaviour:
- Interface decision: one clock (Bit_Rate_CLK_10); reset Reset_n is asynchronous, active-low. All state clears asynchronously on assertion and releases synchronously.
- Reset values: MAC_Ready=0 while Reset_n=0, then 1 from the first clock edge after release. Sym_Data=8'h00, Sym_K=0, Sym_Valid=0, Width_Err=0. Buffer empty, lane index=0.
- Accept: a word is pushed on a rising edge where MAC_Data_En=1 and MAC_Ready=1. DataBusWidth is sampled with the word and stored per entry.
- Lane count per word: 32 gives 4; 16 gives 2; 8 gives 1. Any other value gives 1 lane, and Width_Err=1 on the cycle after acceptance.
- Occupancy FSM, states EMPTY / ONE / TWO:
  - Push only: EMPTY->ONE, ONE->TWO.
  - Pop only: TWO->ONE, ONE->EMPTY.
  - Push and pop in the same cycle: occupancy unchanged.
- MAC_Ready = (state != TWO), combinational from state only. No push while TWO, even if a pop occurs that cycle; this is deliberate, to avoid a ready-to-pop combinational path.
- Emission: each cycle the head entry is non-empty, the block registers byte[lane_idx] and K[lane_idx] onto Sym_Data/Sym_K with Sym_Valid=1.
  - lane_idx increments each emitted cycle.
  - When lane_idx = lanes-1, the head pops and lane_idx wraps to 0.
  - The next entry's byte0 is emitted the very next cycle; there is no bubble.
- Latency: a word accepted at edge N into an EMPTY buffer drives its byte0 on the outputs after edge N+1.
- Empty: Sym_Valid=0. Sym_Data and Sym_K hold their last values; the encoder must ignore them.
- Throughput: a 32-bit word drains in 4 cycles, so sustained MAC rate is at most 1 word per 4 cycles. MAC_Ready backpressure enforces this.
- Width change between consecutive words is legal; each entry uses its own stored lane count.
- Reset mid-word: the partial word is discarded; there is no trailing symbol after release.

Optional Feature:
- Macro: TX_IDLE_FILL_EN.
- Defined:
  - Sym_Valid=1 from the first edge after reset release, and on every cycle thereafter.
  - Cycles with no buffered symbol emit logical idle Sym_Data=8'h00, Sym_K=0.
  - Data symbols are unaffected.
- Undefined: behaviour as above; Sym_Valid=0 when empty.

Decomposition:
- Package tx_pkg:
  - SYM_WIDTH and MAC_WIDTH constants.
  - Width encodings W8=6'd8, W16=6'd16, W32=6'd32.
  - IDLE_SYM=8'h00.
  - Typedef of the buffer entry struct {data[31:0], k[3:0], lanes[2:0]}.
  - Function width_to_lanes(DataBusWidth) returning lanes and an error bit.
- Sub-module tx_sym_fifo2: the 2-entry word FIFO with push/pop/full/empty. The unpacker holds the lane counter and output registers.

Test Plan:
- 32-bit word 32'hBC4A_1C03, K=4'b1000, one push -> Sym_Data 03,1C,4A,BC on 4 consecutive cycles; Sym_K 0,0,0,1; Sym_Valid=1 only those 4 cycles; first byte appears 1 cycle after acceptance.
- Back-to-back 32-bit words with MAC_Data_En held 1 -> MAC_Ready deasserts when state=TWO; the stream has no gap across word boundaries; 8 symbols for 2 words.
- Mixed widths 16 (32'h0000_BBAA), 8 (32'h0000_00CC), 32 (32'h4433_2211) -> AA,BB,CC,11,22,33,44 contiguous.
- DataBusWidth=6'd24 with data 32'h0000_00EE -> single symbol EE; Width_Err pulses once, the cycle after acceptance.
- Reset_n asserted after the 2nd byte of a 32-bit word -> all outputs return to reset values immediately; no further symbols after release until a new push.
- With TX_IDLE_FILL_EN, no input for 5 cycles -> Sym_Valid=1, Sym_Data=00, Sym_K=0 each cycle; then a 16-bit word 32'h0000_5678 -> 78,56, then idle resumes.
